// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: ALU-op encodings, the zero-register number and the bubble control word.
// Imported by the ID/EX stage and its load-use detector.
package id_ex_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOR = 3'd5,
    ALU_XOR = 3'd6,
    ALU_LUI = 3'd7
  } alu_op_e;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  // A bubble never writes anything, so downstream forwarding cannot match it.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle: decoded instruction fields from ID and their registered copies toward EX.
// master = decode side (drives id_*), slave = the ID/EX register (drives ex_*).
interface id_ex_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3
);
  logic                  id_valid;
  logic                  id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
  logic                  id_branch, id_alu_src, id_reg_dst;
  logic [ALUOP_W-1:0]    id_alu_op;
  logic [DATA_W-1:0]     id_pc4, id_rd1, id_rd2, id_imm;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
  logic                  id_uses_rs, id_uses_rt;

  logic                  ex_valid;
  logic                  ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic                  ex_branch, ex_alu_src, ex_reg_dst;
  logic [ALUOP_W-1:0]    ex_alu_op;
  logic [DATA_W-1:0]     ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;

  modport master (
    output id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
           id_branch, id_alu_src, id_reg_dst, id_alu_op, id_pc4, id_rd1, id_rd2,
           id_imm, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
    input  ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, ex_pc4, ex_rd1, ex_rd2,
           ex_imm, ex_rs, ex_rt, ex_rd
  );

  modport slave (
    input  id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
           id_branch, id_alu_src, id_reg_dst, id_alu_op, id_pc4, id_rd1, id_rd2,
           id_imm, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
    output ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, ex_pc4, ex_rd1, ex_rd2,
           ex_imm, ex_rs, ex_rt, ex_rd
  );
endinterface

// File: rtl/id_ex_stage_load_use_detector.sv
// load_use_detector: purely combinational load-use hazard check between the load in EX
// and the instruction currently in ID.
module load_use_detector
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  hazard
);
  logic rs_match, rt_match;

  assign rs_match = id_uses_rs && (id_rs == ex_rt);
  assign rt_match = id_uses_rt && (id_rt == ex_rt);

  // A load into $zero produces nothing worth waiting for.
  assign hazard = ex_valid && ex_mem_read && (ex_rt != REG_ADDR_W'(REG_ZERO)) &&
                  id_valid && (rs_match || rt_match);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch-flush bubble.
// Optional perf counters (bubbles, flushes) are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ext_stall,
  input  logic         flush,
  id_ex_stage_if.slave bus,
  output logic         load_use_stall,
  output logic         if_id_write
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_bubble_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  logic                  valid_q;
  ctrl_t                 ctrl_q;
  ctrl_t                 id_ctrl;
  logic [ALUOP_W-1:0]    alu_op_q;
  logic [DATA_W-1:0]     pc4_q, rd1_q, rd2_q, imm_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic                  hazard;
  logic                  load_bubble;

  assign id_ctrl = '{
    reg_write:  bus.id_reg_write,
    mem_to_reg: bus.id_mem_to_reg,
    mem_read:   bus.id_mem_read,
    mem_write:  bus.id_mem_write,
    branch:     bus.id_branch,
    alu_src:    bus.id_alu_src,
    reg_dst:    bus.id_reg_dst
  };

  load_use_detector #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detector (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (rt_q),
    .id_valid    (bus.id_valid),
    .id_uses_rs  (bus.id_uses_rs),
    .id_uses_rt  (bus.id_uses_rt),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .hazard      (hazard)
  );

  // A flush already kills the ID instruction, so stalling IF/ID for it would be pointless.
  assign load_use_stall = hazard && !flush;
  assign if_id_write    = !(ext_stall || load_use_stall);
  assign load_bubble    = flush || load_use_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= CTRL_BUBBLE;
      alu_op_q <= '0;
      pc4_q    <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else if (!ext_stall) begin
      if (load_bubble) begin
        valid_q  <= 1'b0;
        ctrl_q   <= CTRL_BUBBLE;
        alu_op_q <= '0;
        pc4_q    <= '0;
        rd1_q    <= '0;
        rd2_q    <= '0;
        imm_q    <= '0;
        rs_q     <= '0;
        rt_q     <= '0;
        rd_q     <= '0;
      end else begin
        valid_q  <= bus.id_valid;
        ctrl_q   <= id_ctrl;
        alu_op_q <= bus.id_alu_op;
        pc4_q    <= bus.id_pc4;
        rd1_q    <= bus.id_rd1;
        rd2_q    <= bus.id_rd2;
        imm_q    <= bus.id_imm;
        rs_q     <= bus.id_rs;
        rt_q     <= bus.id_rt;
        rd_q     <= bus.id_rd;
      end
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_branch     = ctrl_q.branch;
  assign bus.ex_alu_src    = ctrl_q.alu_src;
  assign bus.ex_reg_dst    = ctrl_q.reg_dst;
  assign bus.ex_alu_op     = alu_op_q;
  assign bus.ex_pc4        = pc4_q;
  assign bus.ex_rd1        = rd1_q;
  assign bus.ex_rd2        = rd2_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_rs         = rs_q;
  assign bus.ex_rt         = rt_q;
  assign bus.ex_rd         = rd_q;

`ifdef ID_EX_PERF_CNT_EN
  // Saturating counters; frozen along with the pipeline during ext_stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else if (!ext_stall) begin
      if (flush && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      if (load_use_stall && (perf_bubble_cnt != '1))
        perf_bubble_cnt <= perf_bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model predicts each EX state, pushes it to a
// scoreboard queue before the edge, and every test pops and compares after the edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 3;
`ifdef ID_EX_PERF_CNT_EN
  localparam int CNT_W      = 4;
`endif

  typedef struct packed {
    logic        valid, reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst;
    logic [2:0]  alu_op;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ext_stall;
  logic flush;
  logic load_use_stall;
  logic if_id_write;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] perf_bubble_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;
`endif

  id_ex_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W)) bus ();

  id_ex_stage #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W)
`ifdef ID_EX_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ext_stall      (ext_stall),
    .flush          (flush),
    .bus            (bus),
    .load_use_stall (load_use_stall),
    .if_id_write    (if_id_write)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_bubble_cnt (perf_bubble_cnt)
    , .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  ex_t  sb[$];
  ex_t  m_ex, m_id;
  logic m_urs, m_urt;
  int   m_bub, m_fl;
  ex_t  exp_v, got_v;

  function automatic ex_t dut_ex();
    return {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read,
            bus.ex_mem_write, bus.ex_branch, bus.ex_alu_src, bus.ex_reg_dst, bus.ex_alu_op,
            bus.ex_pc4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd};
  endfunction

  function automatic ex_t mk_instr(logic is_load, logic [4:0] rs, logic [4:0] rt,
                                   logic [4:0] rd, logic [31:0] rd1);
    ex_t e = '0;
    e.valid      = 1'b1;
    e.reg_write  = 1'b1;
    e.mem_read   = is_load;
    e.mem_to_reg = is_load;
    e.alu_src    = is_load;
    e.reg_dst    = ~is_load;
    e.alu_op     = is_load ? ALU_ADD : ALU_OR;
    e.pc4        = 32'h0040_0000 + {rd1[7:0], 2'b00};
    e.rd1        = rd1;
    e.rd2        = rd1 ^ 32'hA5A5_0000;
    e.imm        = is_load ? 32'h0000_0010 : 32'hFFFF_FFF0;
    e.rs         = rs;
    e.rt         = rt;
    e.rd         = rd;
    return e;
  endfunction

  function automatic ex_t rand_instr();
    ex_t e;
    e = {$urandom, $urandom, $urandom, $urandom, $urandom};
    e.rs = 5'($urandom_range(0, 3));
    e.rt = 5'($urandom_range(0, 3));
    return e;
  endfunction

  function automatic logic model_lus();
    logic haz;
    haz = m_ex.valid && m_ex.mem_read && (m_ex.rt != 5'd0) && m_id.valid &&
          ((m_urs && m_id.rs == m_ex.rt) || (m_urt && m_id.rt == m_ex.rt));
    return haz && !flush;
  endfunction

`ifdef ID_EX_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat(int n);
    return (n >= (1 << CNT_W) - 1) ? '1 : CNT_W'(n);
  endfunction
`endif

  task automatic drive(input ex_t d, input logic urs, input logic urt);
    m_id = d; m_urs = urs; m_urt = urt;
    bus.id_valid = d.valid;         bus.id_reg_write = d.reg_write;
    bus.id_mem_to_reg = d.mem_to_reg; bus.id_mem_read = d.mem_read;
    bus.id_mem_write = d.mem_write; bus.id_branch = d.branch;
    bus.id_alu_src = d.alu_src;     bus.id_reg_dst = d.reg_dst;
    bus.id_alu_op = d.alu_op;       bus.id_pc4 = d.pc4;
    bus.id_rd1 = d.rd1;             bus.id_rd2 = d.rd2;
    bus.id_imm = d.imm;             bus.id_rs = d.rs;
    bus.id_rt = d.rt;               bus.id_rd = d.rd;
    bus.id_uses_rs = urs;           bus.id_uses_rt = urt;
    #1;
  endtask

  // Predict the EX state for the coming edge, queue it, then take the edge.
  task automatic clock_edge();
    logic lus;
    lus = model_lus();
    if (!ext_stall) begin
      if (flush) m_fl++;
      else if (lus) m_bub++;
      m_ex = (flush || lus) ? '0 : m_id;
    end
    sb.push_back(m_ex);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_ex = '0; m_bub = 0; m_fl = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    #2;
    got_v = dut_ex();
    n_total++;
    if (got_v !== '0) $display("FAIL reset_init ex=%h want 0", got_v); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    drive(mk_instr(1'b0, 5'd3, 5'd4, 5'd7, 32'hDEAD_BEEF), 1'b1, 1'b1);
    clock_edge();
    exp_v = sb.pop_front(); got_v = dut_ex();
    n_total++;
    if (got_v !== exp_v) $display("FAIL reset_load ex=%h want %h", got_v, exp_v); else n_pass++;
    async_reset();
    got_v = dut_ex();
    n_total++;
    if (got_v !== '0) $display("FAIL reset_async ex=%h want 0", got_v); else n_pass++;
    n_total++;
    if (if_id_write !== 1'b1) $display("FAIL reset_ifw got=%b want 1", if_id_write); else n_pass++;
`ifdef ID_EX_PERF_CNT_EN
    n_total++;
    if ({perf_bubble_cnt, perf_flush_cnt} !== '0)
      $display("FAIL reset_cnt got=%h want 0", {perf_bubble_cnt, perf_flush_cnt});
    else n_pass++;
`endif
    drive('0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    ex_t d;
    d = mk_instr(1'b0, 5'd3, 5'd0, 5'd9, 32'h0000_1234);
    drive(d, 1'b1, 1'b0);
    n_total++;
    if ({load_use_stall, if_id_write} !== 2'b01)
      $display("FAIL pt_ctl got=%b want 01", {load_use_stall, if_id_write});
    else n_pass++;
    clock_edge();
    exp_v = sb.pop_front(); got_v = dut_ex();
    n_total++;
    if (got_v !== exp_v || got_v.rd1 !== 32'h1234 || got_v.rs !== 5'd3 || got_v.reg_write !== 1'b1)
      $display("FAIL pt_data ex=%h want %h", got_v, exp_v);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      ext_stall = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 5) == 0);
      drive(rand_instr(), 1'($urandom), 1'($urandom));
      got_v = dut_ex();
      n_total++;
      if (got_v !== m_ex) $display("FAIL pt_no_comb i=%0d ex=%h want %h", i, got_v, m_ex);
      else n_pass++;
      n_total++;
      if ({load_use_stall, if_id_write} !== {model_lus(), !(ext_stall || model_lus())})
        $display("FAIL pt_rand_ctl i=%0d got=%b want %b", i, {load_use_stall, if_id_write},
                 {model_lus(), !(ext_stall || model_lus())});
      else n_pass++;
      clock_edge();
      exp_v = sb.pop_front(); got_v = dut_ex();
      n_total++;
      if (got_v !== exp_v) $display("FAIL pt_rand i=%0d ex=%h want %h", i, got_v, exp_v);
      else n_pass++;
    end
    ext_stall = 1'b0;
    flush     = 1'b0;
    drive('0, 1'b0, 1'b0);
    clock_edge();
    void'(sb.pop_front());
  endtask

  task automatic test_load_use();
    ex_t add_i;
    drive(mk_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h100), 1'b1, 1'b0);
    clock_edge();
    exp_v = sb.pop_front(); got_v = dut_ex();
    n_total++;
    if (got_v !== exp_v) $display("FAIL lu_lw ex=%h want %h", got_v, exp_v); else n_pass++;
    add_i = mk_instr(1'b0, 5'd5, 5'd6, 5'd8, 32'h55);
    drive(add_i, 1'b1, 1'b1);
    n_total++;
    if ({load_use_stall, if_id_write} !== 2'b10)
      $display("FAIL lu_stall got=%b want 10", {load_use_stall, if_id_write});
    else n_pass++;
    clock_edge();
    exp_v = sb.pop_front(); got_v = dut_ex();
    n_total++;
    if (got_v !== exp_v || got_v.rd !== 5'd0 || got_v.reg_write !== 1'b0)
      $display("FAIL lu_bubble ex=%h want %h", got_v, exp_v);
    else n_pass++;
    n_total++;
    if ({load_use_stall, if_id_write} !== 2'b01)
      $display("FAIL lu_clear got=%b want 01", {load_use_stall, if_id_write});
    else n_pass++;
    clock_edge();
    exp_v = sb.pop_front(); got_v = dut_ex();
    n_total++;
    if (got_v !== exp_v || got_v !== add_i) $display("FAIL lu_add ex=%h want %h", got_v, exp_v);
    else n_pass++;
    // Load into $zero must never stall its consumer.
    drive(mk_instr(1'b1, 5'd1, 5'd0, 5'd0, 32'h104), 1'b1, 1'b0);
    clock_edge();
    void'(sb.pop_front());
    drive(mk_instr(1'b0, 5'd0, 5'd0, 5'd8, 32'h66), 1'b1, 1'b1);
    n_total++;
    if ({load_use_stall, if_id_write} !== 2'b01)
      $display("FAIL lu_rt0 got=%b want 01", {load_use_stall, if_id_write});
    else n_pass++;
    clock_edge();
    exp_v = sb.pop_front(); got_v = dut_ex();
    n_total++;
    if (got_v !== exp_v) $display("FAIL lu_rt0_pass ex=%h want %h", got_v, exp_v); else n_pass++;
  endtask

  task automatic test_back_to_back();
    ex_t  prog[3];
    logic urs_a[3], urt_a[3];
    int   pc, bubbles;
    logic in_prog, adv;
    prog[0] = mk_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h200); urs_a[0] = 1'b1; urt_a[0] = 1'b0;
    prog[1] = mk_instr(1'b1, 5'd5, 5'd6, 5'd0, 32'h204); urs_a[1] = 1'b1; urt_a[1] = 1'b0;
    prog[2] = mk_instr(1'b0, 5'd1, 5'd6, 5'd10, 32'h208); urs_a[2] = 1'b1; urt_a[2] = 1'b1;
    pc = 0; bubbles = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      in_prog = (pc < 3);
      if (in_prog) drive(prog[pc], urs_a[pc], urt_a[pc]);
      else drive('0, 1'b0, 1'b0);
      adv = !model_lus();
      n_total++;
      if ({load_use_stall, if_id_write} !== {!adv, adv})
        $display("FAIL b2b_ctl cyc=%0d got=%b want %b", cyc, {load_use_stall, if_id_write}, {!adv, adv});
      else n_pass++;
      clock_edge();
      exp_v = sb.pop_front(); got_v = dut_ex();
      n_total++;
      if (got_v !== exp_v) $display("FAIL b2b_ex cyc=%0d ex=%h want %h", cyc, got_v, exp_v);
      else n_pass++;
      if (in_prog && !got_v.valid) bubbles++;
      if (adv && in_prog) pc++;
    end
    n_total++;
    if (bubbles != 2) $display("FAIL b2b_bubbles got=%0d want 2", bubbles); else n_pass++;
  endtask

  task automatic test_flush();
    drive(mk_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h300), 1'b1, 1'b0);
    clock_edge();
    void'(sb.pop_front());
    drive(mk_instr(1'b0, 5'd5, 5'd6, 5'd8, 32'h77), 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_total++;
    if ({load_use_stall, if_id_write} !== 2'b01)
      $display("FAIL fl_ctl got=%b want 01", {load_use_stall, if_id_write});
    else n_pass++;
    clock_edge();
    flush = 1'b0;
    exp_v = sb.pop_front(); got_v = dut_ex();
    n_total++;
    if (got_v !== exp_v || got_v !== '0) $display("FAIL fl_bubble ex=%h want %h", got_v, exp_v);
    else n_pass++;
`ifdef ID_EX_PERF_CNT_EN
    n_total++;
    if (perf_flush_cnt !== sat(m_fl) || perf_bubble_cnt !== sat(m_bub))
      $display("FAIL fl_cnt got=%h/%h want %h/%h", perf_flush_cnt, perf_bubble_cnt,
               sat(m_fl), sat(m_bub));
    else n_pass++;
`endif
  endtask

  task automatic test_freeze();
    ex_t held;
    held = mk_instr(1'b0, 5'd2, 5'd3, 5'd4, 32'h400);
    drive(held, 1'b1, 1'b1);
    clock_edge();
    void'(sb.pop_front());
    ext_stall = 1'b1;
    flush     = 1'b1;
    drive(mk_instr(1'b0, 5'd9, 5'd10, 5'd11, 32'h404), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (if_id_write !== 1'b0) $display("FAIL frz_ifw i=%0d got=%b want 0", i, if_id_write);
      else n_pass++;
      clock_edge();
      exp_v = sb.pop_front(); got_v = dut_ex();
      n_total++;
      if (got_v !== exp_v || got_v !== held) $display("FAIL frz_hold i=%0d ex=%h want %h", i, got_v, exp_v);
      else n_pass++;
    end
    ext_stall = 1'b0;
    #1;
    clock_edge();
    flush = 1'b0;
    exp_v = sb.pop_front(); got_v = dut_ex();
    n_total++;
    if (got_v !== exp_v) $display("FAIL frz_bubble ex=%h want %h", got_v, exp_v); else n_pass++;
    // Hazard against a frozen load: stall is still reported, EX holds.
    drive(mk_instr(1'b1, 5'd1, 5'd7, 5'd0, 32'h408), 1'b1, 1'b0);
    clock_edge();
    void'(sb.pop_front());
    ext_stall = 1'b1;
    drive(mk_instr(1'b0, 5'd2, 5'd7, 5'd12, 32'h40C), 1'b0, 1'b1);
    n_total++;
    if ({load_use_stall, if_id_write} !== 2'b10)
      $display("FAIL frz_lus got=%b want 10", {load_use_stall, if_id_write});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) ext_stall = 1'b0;
      clock_edge();
      exp_v = sb.pop_front(); got_v = dut_ex();
      n_total++;
      if (got_v !== exp_v) $display("FAIL frz_lu i=%0d ex=%h want %h", i, got_v, exp_v);
      else n_pass++;
    end
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_saturation();
    async_reset();
    drive('0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(mk_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h500), 1'b1, 1'b0);
      clock_edge();
      void'(sb.pop_front());
      drive(mk_instr(1'b0, 5'd5, 5'd2, 5'd3, 32'h504), 1'b1, 1'b0);
      clock_edge();
      exp_v = sb.pop_front(); got_v = dut_ex();
      n_total++;
      if (got_v !== exp_v) $display("FAIL sat_bubble i=%0d ex=%h want %h", i, got_v, exp_v);
      else n_pass++;
    end
    n_total++;
    if (perf_bubble_cnt !== 4'hF) $display("FAIL sat_cnt got=%h want f", perf_bubble_cnt);
    else n_pass++;
    n_total++;
    if (perf_flush_cnt !== 4'h0) $display("FAIL sat_flush got=%h want 0", perf_flush_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; ext_stall = 1'b0; flush = 1'b0;
    m_ex = '0; m_bub = 0; m_fl = 0;
    drive('0, 1'b0, 1'b0);
    rst_n = 1'b0;
    test_reset();
    test_pass_through();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_freeze();
`ifdef ID_EX_PERF_CNT_EN
    test_saturation();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
